// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60Hz defaults), colour field layout and
// the sync/video bundle carried through the latency-matching delay line.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int HS_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int HS_END_DEF   = HS_START_DEF + H_SYNC_DEF;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int VS_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int VS_END_DEF   = VS_START_DEF + V_SYNC_DEF;

  // RRRGGGBB colour byte
  localparam int COLOR_W = 8;
  localparam int R_W     = 3;
  localparam int G_W     = 3;
  localparam int B_W     = 2;
  localparam int B_LSB   = 0;
  localparam int G_LSB   = B_LSB + B_W;
  localparam int R_LSB   = G_LSB + G_W;

  typedef logic [CNT_W-1:0]   coord_t;
  typedef logic [COLOR_W-1:0] color_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic von;
  } sync_bits_t;

  localparam sync_bits_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, von: 1'b0};

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster-side bundle: coordinates and video_on out to the pixel logic, colour back in,
// plus the registered sync/RGB connector pins.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  color_t           color_in;
  coord_t           pixel_x;
  coord_t           pixel_y;
  logic             video_on;
  logic             frame_start;
  logic             hsync_n;
  logic             vsync_n;
  logic [R_W-1:0]   vga_r;
  logic [G_W-1:0]   vga_g;
  logic [B_W-1:0]   vga_b;

  modport master (
    input  color_in,
    output pixel_x, pixel_y, video_on, frame_start,
    output hsync_n, vsync_n, vga_r, vga_g, vga_b
  );

  modport slave (
    output color_in,
    input  pixel_x, pixel_y, video_on, frame_start,
    input  hsync_n, vsync_n, vga_r, vga_g, vga_b
  );

endinterface

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register that shifts every clock; each stage resets to RST_VAL.
module sync_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel-rate counters, sync decode, latency-matched sync/blanking
// and registered DAC pins.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int PIX_DIV  = 2,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int PIPE_DLY = 2
) (
  input  logic           clk,
  input  logic           rst,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_tick, x_last, y_last;
  coord_t           x_q, x_d, y_q, y_d;
  logic             fs_q, fs_d;
  sync_bits_t       raw, dly;
  logic             hs_q, hs_d, vs_q, vs_d;
  logic [R_W-1:0]   r_q, r_d;
  logic [G_W-1:0]   g_q, g_d;
  logic [B_W-1:0]   b_q, b_d;

  assign pix_tick = (div_q == DIV_W'(PIX_DIV - 1));
  assign x_last   = (x_q == CNT_W'(H_TOTAL - 1));
  assign y_last   = (y_q == CNT_W'(V_TOTAL - 1));

  // frame_start is registered so it coincides with the counters reading (0,0)
  always_comb begin
    div_d = pix_tick ? '0 : div_q + DIV_W'(1);
    x_d   = x_q;
    y_d   = y_q;
    fs_d  = 1'b0;
    if (pix_tick) begin
      if (x_last) begin
        x_d = '0;
        if (y_last) begin
          y_d  = '0;
          fs_d = 1'b1;
        end else begin
          y_d = y_q + coord_t'(1);
        end
      end else begin
        x_d = x_q + coord_t'(1);
      end
    end
  end

  assign raw.hs  = !((x_q >= CNT_W'(HS_START)) && (x_q < CNT_W'(HS_END)));
  assign raw.vs  = !((y_q >= CNT_W'(VS_START)) && (y_q < CNT_W'(VS_END)));
  assign raw.von = (x_q < CNT_W'(H_ACTIVE)) && (y_q < CNT_W'(V_ACTIVE));

  // sync and blanking travel alongside the pixel logic's colour latency
  sync_delay_line #(
    .WIDTH   ($bits(sync_bits_t)),
    .DEPTH   (PIPE_DLY),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (raw),
    .dout (dly)
  );

  always_comb begin
    hs_d = dly.hs;
    vs_d = dly.vs;
    r_d  = dly.von ? vga.color_in[R_LSB +: R_W] : '0;
    g_d  = dly.von ? vga.color_in[G_LSB +: G_W] : '0;
    b_d  = dly.von ? vga.color_in[B_LSB +: B_W] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      fs_q  <= 1'b0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
    end else begin
      div_q <= div_d;
      x_q   <= x_d;
      y_q   <= y_d;
      fs_q  <= fs_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      r_q   <= r_d;
      g_q   <= g_d;
      b_q   <= b_d;
    end
  end

  assign vga.pixel_x     = x_q;
  assign vga.pixel_y     = y_q;
  assign vga.video_on    = raw.von;
  assign vga.frame_start = fs_q;
  assign vga.hsync_n     = hs_q;
  assign vga.vsync_n     = vs_q;
  assign vga.vga_r       = r_q;
  assign vga.vga_g       = g_q;
  assign vga.vga_b       = b_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench: default-timing instance plus a shrunken-timing instance (whole frames fit),
// compared every clock against a cycle-count arithmetic model, a vector table and measured runs.
module tb_vga_sync_gen;
  import vga_timing_pkg::*;

  localparam int A_DLY = 2;
  localparam int B_DIV = 3, B_DLY = 3;
  localparam int B_HA = 20, B_HF = 4, B_HS = 6, B_HB = 5;
  localparam int B_VA = 6,  B_VF = 2, B_VS = 2, B_VB = 3;
  localparam int NTAB = 14;

  typedef struct {
    int div, dly, hact, hfp, hsw, hbp, vact, vfp, vsw, vbp;
  } tparam_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       von;
    logic       fs;
    logic       hs;
    logic       vs;
    logic [7:0] rgb;
  } obs_t;

  typedef struct {
    int         k;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic [7:0] rgb;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_sync_gen_if if_a ();
  vga_sync_gen_if if_b ();

  vga_sync_gen u_a (.clk(clk), .rst(rst), .vga(if_a.master));

  vga_sync_gen #(
    .PIX_DIV(B_DIV), .PIPE_DLY(B_DLY),
    .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB)
  ) u_b (.clk(clk), .rst(rst), .vga(if_b.master));

  tparam_t    pa, pb;
  vec_t       tab [NTAB];
  int         tidx;
  logic       tab_on;
  int         k;
  logic       rst_prev;
  int         n_tests, n_fail;
  logic [7:0] salt_a, salt_b;
  logic [9:0] hxa [4], hya [4], hxb [4], hyb [4];
  int         hfall_a, hlen_a, vfall_b, vlen_b;
  logic       hdone_a, vdone_b;
  int         fsq [$];
  obs_t       oa, ob;

  function automatic logic [7:0] colf(logic [9:0] x, logic [9:0] y, logic [7:0] salt);
    return (x[7:0] + {y[4:0], 3'b000}) ^ salt;
  endfunction

  // Expected outputs from the raster rules alone, given clocks elapsed since reset.
  function automatic obs_t model(tparam_t p, int kc, logic [7:0] salt);
    obs_t e;
    int htot, vtot, pix, x, y, kk, x2, y2;
    logic v2;
    htot  = p.hact + p.hfp + p.hsw + p.hbp;
    vtot  = p.vact + p.vfp + p.vsw + p.vbp;
    pix   = kc / p.div;
    x     = pix % htot;
    y     = (pix / htot) % vtot;
    e.x   = 10'(x);
    e.y   = 10'(y);
    e.von = (x < p.hact) && (y < p.vact);
    e.fs  = (kc > 0) && (kc % (p.div * htot * vtot) == 0);
    if (kc < p.dly + 1) begin
      e.hs  = 1'b1;
      e.vs  = 1'b1;
      e.rgb = 8'h00;
    end else begin
      kk    = kc - p.dly - 1;
      pix   = kk / p.div;
      x2    = pix % htot;
      y2    = (pix / htot) % vtot;
      v2    = (x2 < p.hact) && (y2 < p.vact);
      e.hs  = !((x2 >= p.hact + p.hfp) && (x2 < p.hact + p.hfp + p.hsw));
      e.vs  = !((y2 >= p.vact + p.vfp) && (y2 < p.vact + p.vfp + p.vsw));
      e.rgb = v2 ? colf(10'(x2), 10'(y2), salt) : 8'h00;
    end
    return e;
  endfunction

  task automatic chk(input string name, input obs_t got, input obs_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d got x=%0d y=%0d von=%b fs=%b hs=%b vs=%b rgb=%h, want x=%0d y=%0d von=%b fs=%b hs=%b vs=%b rgb=%h",
               name, k, got.x, got.y, got.von, got.fs, got.hs, got.vs, got.rgb,
               exp.x, exp.y, exp.von, exp.fs, exp.hs, exp.vs, exp.rgb);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", name, got, exp);
    end
  endtask

  task automatic clear_meas();
    hfall_a = -1; hlen_a = 0; hdone_a = 1'b0;
    vfall_b = -1; vlen_b = 0; vdone_b = 1'b0;
    fsq.delete();
  endtask

  // One clock: observe after the edge, check, then drive the next inputs.
  task automatic cycle(input logic rst_next);
    logic [28:0] tgot, texp;
    @(negedge clk);
    if (rst_prev) k = 0; else k++;
    oa = {if_a.pixel_x, if_a.pixel_y, if_a.video_on, if_a.frame_start,
          if_a.hsync_n, if_a.vsync_n, if_a.vga_r, if_a.vga_g, if_a.vga_b};
    ob = {if_b.pixel_x, if_b.pixel_y, if_b.video_on, if_b.frame_start,
          if_b.hsync_n, if_b.vsync_n, if_b.vga_r, if_b.vga_g, if_b.vga_b};
    chk("model_a", oa, model(pa, k, salt_a));
    chk("model_b", ob, model(pb, k, salt_b));

    if (tab_on && tidx < NTAB && k == tab[tidx].k) begin
      tgot = {oa.x, oa.y, oa.hs, oa.rgb};
      texp = {tab[tidx].x, tab[tidx].y, tab[tidx].hs, tab[tidx].rgb};
      n_tests++;
      if (tgot !== texp) begin
        n_fail++;
        $display("FAIL vec%0d k=%0d got x=%0d y=%0d hs=%b rgb=%h want x=%0d y=%0d hs=%b rgb=%h",
                 tidx, k, oa.x, oa.y, oa.hs, oa.rgb,
                 tab[tidx].x, tab[tidx].y, tab[tidx].hs, tab[tidx].rgb);
      end
      tidx++;
    end

    if (!rst_prev) begin
      if (hfall_a < 0 && !oa.hs) hfall_a = k;
      if (hfall_a >= 0 && !hdone_a) begin
        if (!oa.hs) hlen_a++; else hdone_a = 1'b1;
      end
      if (vfall_b < 0 && !ob.vs) vfall_b = k;
      if (vfall_b >= 0 && !vdone_b) begin
        if (!ob.vs) vlen_b++; else vdone_b = 1'b1;
      end
      if (ob.fs) fsq.push_back(k);
    end

    for (int i = 3; i > 0; i--) begin
      hxa[i] = hxa[i-1]; hya[i] = hya[i-1];
      hxb[i] = hxb[i-1]; hyb[i] = hyb[i-1];
    end
    hxa[0] = if_a.pixel_x; hya[0] = if_a.pixel_y;
    hxb[0] = if_b.pixel_x; hyb[0] = if_b.pixel_y;
    if_a.color_in = colf(hxa[A_DLY], hya[A_DLY], salt_a);
    if_b.color_in = colf(hxb[B_DLY], hyb[B_DLY], salt_b);
    rst      = rst_next;
    rst_prev = rst_next;
  endtask

  initial begin
    pa = '{2, A_DLY, H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF,
           V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF};
    pb = '{B_DIV, B_DLY, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB};

    // {k, pixel_x, pixel_y, hsync_n, rgb} for the default instance with colour = pixel_x
    tab[0]  = '{0,    10'd0,   10'd0, 1'b1, 8'h00};
    tab[1]  = '{3,    10'd1,   10'd0, 1'b1, 8'h00};
    tab[2]  = '{13,   10'd6,   10'd0, 1'b1, 8'h05};
    tab[3]  = '{14,   10'd7,   10'd0, 1'b1, 8'h05};
    tab[4]  = '{451,  10'd225, 10'd0, 1'b1, 8'hE0};
    tab[5]  = '{1281, 10'd640, 10'd0, 1'b1, 8'h7F};
    tab[6]  = '{1283, 10'd641, 10'd0, 1'b1, 8'h00};
    tab[7]  = '{1314, 10'd657, 10'd0, 1'b1, 8'h00};
    tab[8]  = '{1315, 10'd657, 10'd0, 1'b0, 8'h00};
    tab[9]  = '{1506, 10'd753, 10'd0, 1'b0, 8'h00};
    tab[10] = '{1507, 10'd753, 10'd0, 1'b1, 8'h00};
    tab[11] = '{1599, 10'd799, 10'd0, 1'b1, 8'h00};
    tab[12] = '{1600, 10'd0,   10'd1, 1'b1, 8'h00};
    tab[13] = '{1603, 10'd1,   10'd1, 1'b1, 8'h08};

    n_tests = 0; n_fail = 0; tidx = 0; tab_on = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hxa[i] = '0; hya[i] = '0; hxb[i] = '0; hyb[i] = '0;
    end
    salt_a = 8'h00;
    salt_b = 8'($urandom);
    if_a.color_in = 8'h00;
    if_b.color_in = 8'h00;
    rst = 1'b1; rst_prev = 1'b1; k = 0;
    clear_meas();

    cycle(1'b1);
    cycle(1'b1);
    tab_on = 1'b1;
    cycle(1'b0);
    while (k < 2199) cycle(1'b0);
    cycle(1'b1);
    chk_int("pre_rst_x", int'(oa.x), 300);
    chk_int("pre_rst_y", int'(oa.y), 1);
    chk_int("vec_all_hit", tidx, NTAB);
    chk_int("hs_fall_a", hfall_a, HS_START_DEF * 2 + A_DLY + 1);
    chk_int("hs_len_a", hlen_a, H_SYNC_DEF * 2);
    chk_int("vs_fall_b", vfall_b, (B_VA + B_VF) * 35 * B_DIV + B_DLY + 1);
    chk_int("vs_len_b", vlen_b, B_VS * 35 * B_DIV);
    chk_int("fs_b_first", (fsq.size() > 0) ? fsq[0] : -1, 13 * 35 * B_DIV);

    tab_on = 1'b0;
    salt_a = 8'($urandom);
    salt_b = 8'($urandom);
    clear_meas();
    cycle(1'b0);
    chk("mid_rst_a", oa, {10'd0, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00});
    repeat (2800) cycle(1'b0);
    chk_int("vs_fall_b2", vfall_b, (B_VA + B_VF) * 35 * B_DIV + B_DLY + 1);
    chk_int("vs_len_b2", vlen_b, B_VS * 35 * B_DIV);
    chk_int("fs_b_after_rst", (fsq.size() > 0) ? fsq[0] : -1, 13 * 35 * B_DIV);
    chk_int("fs_b_period", (fsq.size() > 1) ? fsq[1] - fsq[0] : -1, 13 * 35 * B_DIV);
    chk_int("fs_b_count", fsq.size(), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
